spi_slave: RTL and testbench

Transmit-only SPI slave that presents a 32-bit word, loaded from the FPGA fabric, to an external SPI master on MISO. The fabric writes the word with a one-cycle `data_valid` strobe. The host master then reads it in one 32-clock frame, SPI mode 0, MSB first. All logic runs in the `clk` domain; the SCLK and CS_n pins are synchronised and edge-detected internally.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 47 ++++
 rtl/spi_slave.sv | 95 +++++++++
 tb/tb_spi_slave.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared defaults and FSM state type for the SPI slave
package spi_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - N-stage pin synchroniser with rise/fall pulse outputs
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic rise,
    output logic fall
);

    localparam int FW = $clog2(STAGES + 2);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [FW-1:0]     fill_q, fill_d;
    logic              level;

    assign level = sync_q[STAGES-1];

    // Edges stay masked until the chain has refilled from the pin after reset,
    // so a pin held at the opposite level does not look like an edge on release.
    always_comb begin
        sync_d[0] = pin;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = level;
        fill_d = (fill_q != '0) ? fill_q - 1'b1 : fill_q;
        rise   = (fill_q == '0) &&  level && !prev_q;
        fall   = (fill_q == '0) && !level &&  prev_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            fill_q <= FW'(STAGES + 1);
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - transmit-only SPI mode-0 slave presenting one fabric word per frame
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              SCLK,
    input  logic              CS_n,
    output logic              MISO
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    spi_state_t        state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              miso_q, miso_d;

    logic sclk_fall, sclk_rise_unused;
    logic cs_fall, cs_rise;

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .pin   (SCLK),
        .rise  (sclk_rise_unused),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .reset (reset),
        .pin   (CS_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_comb begin
        hold_d  = data_valid ? data_in : hold_q;
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // A write landing on the start cycle bypasses the holding register.
                if (cs_fall) begin
                    state_d = SHIFT;
                    sr_d    = data_valid ? data_in : hold_q;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_fall && (cnt_q != CNT_W'(DATA_W))) begin
                    sr_d  = {sr_q[DATA_W-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        miso_d = (state_d == SHIFT) ? sr_d[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
        end
    end

    assign MISO = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        SCLK = 1'b0;
    logic        CS_n = 1'b1;
    logic        MISO;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] rx;
    logic [31:0] words [10];

    spi_slave #(
        .DATA_W      (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_valid (data_valid),
        .data_in    (data_in),
        .SCLK       (SCLK),
        .CS_n       (CS_n),
        .MISO       (MISO)
    );

    always #16 clk = ~clk;

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #4;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] w);
        @(posedge clk);
        #4;
        data_valid = 1'b1;
        data_in    = w;
        @(posedge clk);
        #4;
        data_valid = 1'b0;
        data_in    = 'x;
    endtask

    task automatic frame_begin();
        rx   = '0;
        CS_n = 1'b0;
        clk_wait(8);
    endtask

    // Master samples MISO just before each SCLK rise; the slave shifts on the fall.
    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            rx   = {rx[62:0], MISO};
            SCLK = 1'b1;
            clk_wait(4);
            SCLK = 1'b0;
            clk_wait(4);
        end
    endtask

    task automatic frame_end();
        CS_n = 1'b1;
        clk_wait(8);
    endtask

    task automatic spi_read(input int n);
        frame_begin();
        shift_bits(n);
        frame_end();
    endtask

    initial begin
        clk_wait(3);
        reset = 1'b0;
        clk_wait(5);
        check("reset_miso", {63'd0, MISO}, 64'd0);

        write_word(32'hDEADBEEF);
        spi_read(32);
        check("basic_read", rx, 64'h00000000_DEADBEEF);

        for (int k = 0; k < 10; k++) begin
            words[k] = $urandom;
            write_word(words[k]);
            clk_wait(300);
            spi_read(32);
            check($sformatf("seq_word%0d", k), rx, {32'd0, words[k]});
        end

        write_word(32'h12345678);
        frame_begin();
        shift_bits(16);
        write_word(32'hA5A5A5A5);
        shift_bits(16);
        frame_end();
        check("write_mid_frame_cur", rx, 64'h00000000_12345678);
        spi_read(32);
        check("write_mid_frame_next", rx, 64'h00000000_A5A5A5A5);

        spi_read(32);
        check("repeat_read", rx, 64'h00000000_A5A5A5A5);

        write_word(32'h80000001);
        spi_read(8);
        check("abort_partial", rx, 64'h80);
        spi_read(32);
        check("abort_full", rx, 64'h00000000_80000001);

        write_word(32'hFFFFFFFF);
        frame_begin();
        shift_bits(4);
        check("pre_reset_miso", {63'd0, MISO}, 64'd1);
        reset = 1'b1;
        clk_wait(1);
        reset = 1'b0;
        clk_wait(1);
        check("reset_mid_frame_miso", {63'd0, MISO}, 64'd0);
        rx = '0;
        shift_bits(6);
        check("dead_after_reset", rx, 64'd0);
        frame_end();
        spi_read(32);
        check("read_after_reset", rx, 64'd0);

        write_word(32'hFFFFFFFF);
        spi_read(40);
        check("overclocked", rx, 64'h000000FF_FFFFFF00);

        check("idle_miso", {63'd0, MISO}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
